// File: rtl/cap_charge_fire_ctrl.sv
// cap_charge_fire_ctrl: charge/fire sequencer for the IGBT/SCR pulse stage.
// Charges two resonant caps, reports ready, then fires IGBT, dead time, SCR; latches faults.
module cap_charge_fire_ctrl #(
    parameter int unsigned CHARGE_TIMEOUT = 50_000_000,
    parameter int unsigned SETTLE_CYC     = 500,
    parameter int unsigned IGBT_PW        = 1000,
    parameter int unsigned DEAD_CYC       = 100,
    parameter int unsigned SCR_PW         = 500,
    parameter int unsigned HOLDOFF_CYC    = 5000
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        arm,
    input  logic        fire_req,
    input  logic [2:0]  voltage_cap_flag,
    input  logic        fault_in,
    output logic [1:0]  charge_en,
    output logic        igbt_gate,
    output logic        scr_gate,
    output logic        ready,
    output logic [2:0]  state,
    output logic [1:0]  err_code,
    output logic [15:0] pulse_cnt
);
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CHARGE    = 3'd1,
        S_READY     = 3'd2,
        S_FIRE_IGBT = 3'd3,
        S_DEAD      = 3'd4,
        S_FIRE_SCR  = 3'd5,
        S_HOLDOFF   = 3'd6,
        S_FAULT     = 3'd7
    } state_t;

    localparam logic [31:0] L_TMO  = (CHARGE_TIMEOUT == 0) ? 32'd1 : 32'(CHARGE_TIMEOUT);
    localparam logic [15:0] L_SET  = (SETTLE_CYC == 0)  ? 16'd1 : 16'(SETTLE_CYC);
    localparam logic [15:0] L_IGBT = (IGBT_PW == 0)     ? 16'd1 : 16'(IGBT_PW);
    localparam logic [15:0] L_DEAD = (DEAD_CYC == 0)    ? 16'd1 : 16'(DEAD_CYC);
    localparam logic [15:0] L_SCR  = (SCR_PW == 0)      ? 16'd1 : 16'(SCR_PW);
    localparam logic [15:0] L_HOLD = (HOLDOFF_CYC == 0) ? 16'd1 : 16'(HOLDOFF_CYC);

    state_t      r_state;
    logic [31:0] r_tmo;
    logic [15:0] r_set0, r_set1, r_ph, r_cnt;
    logic [1:0]  r_chg, r_err;
    logic        r_igbt, r_scr, r_rdy, r_drop;

    logic [31:0] w_tmo_n;
    logic [15:0] w_set0_n, w_set1_n, w_ph_n, w_cnt_n;
    logic [1:0]  w_err_f;
    logic        w_ok0, w_ok1, w_unused;

    // Settle counters saturate at the threshold so a long-held flag never wraps.
    assign w_set0_n = voltage_cap_flag[0] ? ((r_set0 >= L_SET) ? r_set0 : r_set0 + 16'd1) : 16'd0;
    assign w_set1_n = voltage_cap_flag[1] ? ((r_set1 >= L_SET) ? r_set1 : r_set1 + 16'd1) : 16'd0;
    assign w_ok0    = w_set0_n >= L_SET;
    assign w_ok1    = w_set1_n >= L_SET;
    assign w_tmo_n  = r_tmo + 32'd1;
    assign w_ph_n   = r_ph + 16'd1;
    assign w_cnt_n  = (&r_cnt) ? r_cnt : r_cnt + 16'd1;
    assign w_err_f  = (r_err == 2'b01) ? 2'b01 : 2'b10;
    assign w_unused = voltage_cap_flag[2];

    // Counters and outputs default to zero every edge; only the states that keep them alive override.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= S_IDLE;
            r_tmo   <= '0;
            r_set0  <= '0;
            r_set1  <= '0;
            r_ph    <= '0;
            r_cnt   <= '0;
            r_chg   <= '0;
            r_err   <= '0;
            r_igbt  <= 1'b0;
            r_scr   <= 1'b0;
            r_rdy   <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_tmo  <= '0;
            r_set0 <= '0;
            r_set1 <= '0;
            r_ph   <= '0;
            r_chg  <= '0;
            r_igbt <= 1'b0;
            r_scr  <= 1'b0;
            r_rdy  <= 1'b0;
            r_drop <= r_drop | ~arm;
            if (fault_in && r_state != S_FAULT) begin
                r_state <= S_FAULT;
                r_err   <= w_err_f;
            end else begin
                case (r_state)
                    S_IDLE: if (arm) begin
                        r_state <= S_CHARGE;
                        r_chg   <= 2'b11;
                        r_err   <= 2'b00;
                    end
                    S_CHARGE: if (!arm) begin
                        r_state <= S_IDLE;
                    end else if (w_tmo_n >= L_TMO) begin
                        r_state <= S_FAULT;
                        r_err   <= 2'b01;
                    end else if (w_ok0 && w_ok1) begin
                        r_state <= S_READY;
                        r_rdy   <= 1'b1;
                    end else begin
                        r_tmo  <= w_tmo_n;
                        r_set0 <= w_set0_n;
                        r_set1 <= w_set1_n;
                        r_chg  <= {~w_ok1, ~w_ok0};
                    end
                    S_READY: if (!arm) begin
                        r_state <= S_IDLE;
                    end else if (voltage_cap_flag[1:0] != 2'b11) begin
                        r_state <= S_CHARGE;
                        r_chg   <= 2'b11;
                    end else if (fire_req) begin
                        r_state <= S_FIRE_IGBT;
                        r_igbt  <= 1'b1;
                        r_cnt   <= w_cnt_n;
                        r_drop  <= 1'b0;
                    end else begin
                        r_rdy <= 1'b1;
                    end
                    S_FIRE_IGBT: if (w_ph_n >= L_IGBT) begin
                        r_state <= S_DEAD;
                    end else begin
                        r_ph   <= w_ph_n;
                        r_igbt <= 1'b1;
                    end
                    S_DEAD: if (w_ph_n >= L_DEAD) begin
                        r_state <= S_FIRE_SCR;
                        r_scr   <= 1'b1;
                    end else begin
                        r_ph <= w_ph_n;
                    end
                    S_FIRE_SCR: if (w_ph_n >= L_SCR) begin
                        r_state <= (r_drop || !arm) ? S_IDLE : S_HOLDOFF;
                    end else begin
                        r_ph  <= w_ph_n;
                        r_scr <= 1'b1;
                    end
                    S_HOLDOFF: if (w_ph_n >= L_HOLD) begin
                        r_state <= arm ? S_CHARGE : S_IDLE;
                        r_chg   <= arm ? 2'b11 : 2'b00;
                    end else begin
                        r_ph <= w_ph_n;
                    end
                    S_FAULT: if (!fault_in && !arm) begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign charge_en = r_chg;
    assign igbt_gate = r_igbt;
    assign scr_gate  = r_scr;
    assign ready     = r_rdy;
    assign state     = r_state;
    assign err_code  = r_err;
    assign pulse_cnt = r_cnt;
endmodule

// File: tb/tb_cap_charge_fire_ctrl.sv
// tb_cap_charge_fire_ctrl: directed bench for cap_charge_fire_ctrl with small phase parameters.
module tb_cap_charge_fire_ctrl;
    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        arm = 1'b0;
    logic        fire_req = 1'b0;
    logic [2:0]  voltage_cap_flag = 3'b000;
    logic        fault_in = 1'b0;
    logic [1:0]  charge_en;
    logic        igbt_gate, scr_gate, ready;
    logic [2:0]  state;
    logic [1:0]  err_code;
    logic [15:0] pulse_cnt;
    int          vectors = 0;
    int          miscompares = 0;

    cap_charge_fire_ctrl #(
        .CHARGE_TIMEOUT(100), .SETTLE_CYC(4), .IGBT_PW(10),
        .DEAD_CYC(3), .SCR_PW(5), .HOLDOFF_CYC(8)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .arm(arm), .fire_req(fire_req),
        .voltage_cap_flag(voltage_cap_flag), .fault_in(fault_in),
        .charge_en(charge_en), .igbt_gate(igbt_gate), .scr_gate(scr_gate),
        .ready(ready), .state(state), .err_code(err_code), .pulse_cnt(pulse_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Gate exclusivity and charger lockout are checked on every falling edge.
    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            vectors++;
            assert (!(igbt_gate && scr_gate) &&
                    !((igbt_gate || scr_gate || state == 3'd4) && charge_en != 2'b00)) else begin
                miscompares++;
                $error("FAIL invariant: igbt %0b scr %0b chg %0b state %0d expected no overlap and chg 0",
                       igbt_gate, scr_gate, charge_en, state);
            end
        end
    end

    initial begin
        tick(2);
        chk("rst_state", state, 0);
        chk("rst_outs", {charge_en, igbt_gate, scr_gate, ready, err_code}, 0);
        chk("rst_cnt", pulse_cnt, 0);
        sys_rst = 1'b0;
        // 1: charge with both flags held (bit2 set to show it is ignored)
        arm = 1'b1;
        voltage_cap_flag = 3'b111;
        tick(1);
        chk("t1_state_chg", state, 1);
        chk("t1_chg11", charge_en, 2'b11);
        tick(3);
        chk("t1_still_chg", {state, charge_en}, {3'd1, 2'b11});
        tick(1);
        chk("t1_ready", {state, ready, charge_en}, {3'd2, 1'b1, 2'b00});
        // 2: full fire sequence
        fire_req = 1'b1;
        tick(1);
        fire_req = 1'b0;
        chk("t2_igbt_on", {state, igbt_gate, scr_gate, ready}, {3'd3, 1'b1, 1'b0, 1'b0});
        chk("t2_cnt", pulse_cnt, 1);
        tick(9);
        chk("t2_igbt_last", {state, igbt_gate}, {3'd3, 1'b1});
        tick(1);
        chk("t2_dead", {state, igbt_gate, scr_gate}, {3'd4, 1'b0, 1'b0});
        tick(2);
        chk("t2_dead_last", {state, scr_gate}, {3'd4, 1'b0});
        tick(1);
        chk("t2_scr_on", {state, scr_gate}, {3'd5, 1'b1});
        tick(4);
        chk("t2_scr_last", {state, scr_gate}, {3'd5, 1'b1});
        tick(1);
        chk("t2_holdoff", {state, scr_gate}, {3'd6, 1'b0});
        tick(7);
        chk("t2_holdoff_last", state, 6);
        tick(1);
        chk("t2_recharge", {state, charge_en}, {3'd1, 2'b11});
        chk("t2_cnt_hold", pulse_cnt, 1);
        tick(4);
        chk("t2_ready_again", state, 2);
        // 5: fire_req ignored in IDLE and CHARGE
        arm = 1'b0;
        tick(1);
        chk("t5_idle", state, 0);
        fire_req = 1'b1;
        tick(1);
        fire_req = 1'b0;
        chk("t5_idle_fire", {state, igbt_gate, pulse_cnt}, {3'd0, 1'b0, 16'd1});
        arm = 1'b1;
        tick(1);
        fire_req = 1'b1;
        tick(1);
        fire_req = 1'b0;
        chk("t5_chg_fire", {state, igbt_gate, pulse_cnt}, {3'd1, 1'b0, 16'd1});
        tick(3);
        chk("t5_ready", state, 2);
        // 6: flag1 glitch in READY
        voltage_cap_flag = 3'b001;
        tick(1);
        voltage_cap_flag = 3'b011;
        chk("t6_back_chg", {state, charge_en[1], ready}, {3'd1, 1'b1, 1'b0});
        tick(3);
        chk("t6_chg_wait", state, 1);
        tick(1);
        chk("t6_ready", {state, ready}, {3'd2, 1'b1});
        // 4: external fault mid IGBT pulse
        fire_req = 1'b1;
        tick(1);
        fire_req = 1'b0;
        chk("t4_cnt", pulse_cnt, 2);
        tick(3);
        chk("t4_igbt_c4", igbt_gate, 1);
        fault_in = 1'b1;
        tick(1);
        chk("t4_fault", {state, igbt_gate, scr_gate, charge_en, err_code}, {3'd7, 1'b0, 1'b0, 2'b00, 2'b10});
        fault_in = 1'b0;
        tick(2);
        chk("t4_stay_fault", {state, err_code}, {3'd7, 2'b10});
        arm = 1'b0;
        tick(1);
        chk("t4_idle_err", {state, err_code}, {3'd0, 2'b10});
        arm = 1'b1;
        tick(1);
        chk("t4_err_clr", {state, err_code}, {3'd1, 2'b00});
        arm = 1'b0;
        tick(1);
        // 3: charge timeout with cap2 never reaching setpoint
        voltage_cap_flag = 3'b001;
        arm = 1'b1;
        tick(1);
        chk("t3_entry", {state, charge_en}, {3'd1, 2'b11});
        tick(5);
        chk("t3_cap2_only", charge_en, 2'b10);
        tick(94);
        chk("t3_before_tmo", {state, charge_en}, {3'd1, 2'b10});
        tick(1);
        chk("t3_tmo", {state, err_code, charge_en, ready, igbt_gate, scr_gate}, {3'd7, 2'b01, 2'b00, 3'b000});
        arm = 1'b0;
        tick(1);
        chk("t3_idle", {state, err_code}, {3'd0, 2'b01});
        arm = 1'b1;
        tick(1);
        chk("t3_err_clr", {state, err_code}, {3'd1, 2'b00});
        // arm dropped during firing: sequence completes, then IDLE without holdoff
        voltage_cap_flag = 3'b011;
        tick(4);
        chk("dis_ready", state, 2);
        fire_req = 1'b1;
        tick(1);
        fire_req = 1'b0;
        arm = 1'b0;
        tick(9);
        chk("dis_igbt_full", {state, igbt_gate}, {3'd3, 1'b1});
        tick(4);
        chk("dis_scr", {state, scr_gate}, {3'd5, 1'b1});
        tick(5);
        chk("dis_idle", {state, scr_gate, pulse_cnt}, {3'd0, 1'b0, 16'd3});
        // reset mid-pulse drops the gate at that edge
        arm = 1'b1;
        tick(5);
        fire_req = 1'b1;
        tick(1);
        fire_req = 1'b0;
        chk("rp_igbt", {state, igbt_gate, pulse_cnt}, {3'd3, 1'b1, 16'd4});
        sys_rst = 1'b1;
        tick(1);
        chk("rp_reset", {state, igbt_gate, pulse_cnt}, {3'd0, 1'b0, 16'd0});
        sys_rst = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
